// File: rtl/ub_read_streamer.sv
// Unified-buffer read streamer: fetches a contiguous burst of SRAM words and
// streams them in order over valid/ready. A 2-entry skid FIFO covers the
// 1-cycle SRAM read latency so the stream can run at one word per cycle.
module ub_read_streamer #(
    parameter int unsigned ADDRESSSIZE = 10,
    parameter int unsigned WORDSIZE    = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE:0]   length,
    output logic                   busy,
    output logic                   done,
    output logic                   sram_read_enable,
    output logic                   sram_write_enable,
    output logic [ADDRESSSIZE-1:0] sram_address,
    input  logic [WORDSIZE-1:0]    sram_data_out,
    output logic                   out_valid,
    output logic [WORDSIZE-1:0]    out_data,
    output logic                   out_last,
    input  logic                   out_ready
);

    localparam int unsigned LW = ADDRESSSIZE + 1;
    localparam int unsigned AW = ADDRESSSIZE;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [LW-1:0]       len_q, len_d;
    logic [LW-1:0]       issued_q, issued_d;
    logic [LW-1:0]       beat_q, beat_d;
    logic                pend_q, pend_d;
    logic [WORDSIZE-1:0] fifo_q [2];
    logic [WORDSIZE-1:0] fifo_d [2];
    logic                head_q, head_d;
    logic [1:0]          count_q, count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [WORDSIZE-1:0] data_q, data_d;

    logic                pop_c;
    logic [2:0]          occ_c;
    logic                rd_c;

    // Issue decision: a new read may go out if the slots it would occupy are free
    assign pop_c = valid_q & out_ready;
    assign occ_c = 3'(count_q) + 3'(pend_q) - 3'(pop_c);
    assign rd_c  = (state_q == ST_RUN) && (issued_q < len_q) && (occ_c < 3'd2);

    assign busy              = busy_q;
    assign done              = done_q;
    assign sram_read_enable  = rd_c;
    assign sram_write_enable = 1'b0;
    assign sram_address      = addr_q;
    assign out_valid         = valid_q;
    assign out_data          = data_q;
    assign out_last          = last_q;

    // Next-state: FSM, address/issue counters, skid FIFO and registered outputs
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        issued_d  = issued_q;
        beat_d    = beat_q;
        pend_d    = rd_c;
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        head_d    = head_q;
        count_d   = count_q;
        data_d    = data_q;

        // Capture returning word at the tail; pop the head on handshake
        if (pend_q) begin
            fifo_d[head_q ^ count_q[0]] = sram_data_out;
        end
        if (pop_c) begin
            head_d = ~head_q;
            beat_d = beat_q + LW'(1);
        end
        count_d = count_q + {1'b0, pend_q} - {1'b0, pop_c};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d  = ST_RUN;
                        len_d    = length;
                        addr_d   = base_addr;
                        issued_d = '0;
                        beat_d   = '0;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RUN: begin
                if (rd_c) begin
                    addr_d   = addr_q + AW'(1);
                    issued_d = issued_q + LW'(1);
                    if (issued_q + LW'(1) == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop_c && (beat_q + LW'(1) == len_q)) begin
                    state_d = ST_FIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (count_d != 2'd0);
        if (valid_d) begin
            data_d = fifo_d[head_d];
        end
        last_d = valid_d && (beat_d + LW'(1) == len_q);
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_FIN);
    end

    // State and output registers; reset discards any read still in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            beat_q    <= '0;
            pend_q    <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            head_q    <= 1'b0;
            count_q   <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            beat_q    <= beat_d;
            pend_q    <= pend_d;
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            head_q    <= head_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: tb/tb_ub_read_streamer.sv
// Bench for ub_read_streamer: SRAM model, table of bursts plus random bursts,
// each checked cycle by cycle against a burst-level reference of the stream.
module tb_ub_read_streamer;

    localparam int unsigned AS = 10;
    localparam int unsigned WS = 64;
    localparam int unsigned DEPTH = 1 << AS;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [AS-1:0] base_addr;
    logic [AS:0]   length;
    logic          busy;
    logic          done;
    logic          sram_read_enable;
    logic          sram_write_enable;
    logic [AS-1:0] sram_address;
    logic [WS-1:0] sram_data_out;
    logic          out_valid;
    logic [WS-1:0] out_data;
    logic          out_last;
    logic          out_ready;

    logic [WS-1:0] mem [DEPTH];

    int tests;
    int fails;

    typedef struct {
        int base;
        int len;
        int pct;       // percent of cycles with out_ready high
        int x1;        // cycle index of a stray start (0 = none)
        int x2;
        int exp_done;  // expected done cycle after acceptance (0 = unchecked)
    } vec_t;

    vec_t tbl [14];

    ub_read_streamer #(.ADDRESSSIZE(AS), .WORDSIZE(WS)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .start             (start),
        .base_addr         (base_addr),
        .length            (length),
        .busy              (busy),
        .done              (done),
        .sram_read_enable  (sram_read_enable),
        .sram_write_enable (sram_write_enable),
        .sram_address      (sram_address),
        .sram_data_out     (sram_data_out),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_last          (out_last),
        .out_ready         (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read SRAM, one cycle latency
    always @(posedge clk) begin
        if (sram_read_enable) sram_data_out <= mem[sram_address];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_rd"}, sram_read_enable, 1'b0);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_we"}, sram_write_enable, 1'b0);
    endtask

    // One burst: start in an idle cycle, then check every cycle until done
    task automatic run_burst(input vec_t v);
        int k;
        int issued;
        int popped;
        bit pv;
        bit fin;
        logic [WS-1:0] pd;
        logic [AS-1:0] a;
        @(posedge clk); #1;
        base_addr = AS'(v.base);
        length    = (AS+1)'(v.len);
        start     = 1'b1;
        out_ready = ($urandom_range(99) < v.pct);
        @(posedge clk);
        k = 0; issued = 0; popped = 0; pv = 1'b0; fin = 1'b0; pd = '0;
        while (!fin) begin
            k++;
            #1;
            start = (k == v.x1) || (k == v.x2);
            if (start) begin
                base_addr = AS'($urandom);
                length    = (AS+1)'($urandom_range(3, 9));
            end
            out_ready = ($urandom_range(99) < v.pct);
            @(negedge clk);
            chk("we", sram_write_enable, 1'b0);
            chk("busy", busy, (v.len != 0) && !done);
            if (k == 1) chk("first_strobe", sram_read_enable, v.len != 0);
            if (k < 3) chk("early_valid", out_valid, 1'b0);
            if (k == 3 && v.len != 0) chk("first_valid", out_valid, 1'b1);
            if (pv) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, pd);
            end
            if (sram_read_enable) begin
                a = AS'(v.base + issued);
                chk("issue_bound", issued < v.len, 1'b1);
                chk("addr", sram_address, a);
                issued++;
            end
            if (out_valid) begin
                chk("beat_bound", popped < v.len, 1'b1);
                chk("last", out_last, popped == v.len - 1);
                if (out_ready) begin
                    a = AS'(v.base + popped);
                    chk("data", out_data, mem[a]);
                    popped++;
                end
            end
            pv = out_valid && !out_ready;
            pd = out_data;
            chk("occupancy", (issued - popped) <= 2, 1'b1);
            if (done) begin
                chk("done_beats", popped, v.len);
                chk("done_issues", issued, v.len);
                if (v.exp_done != 0) chk("done_cycle", k, v.exp_done);
                fin = 1'b1;
            end else if (k > 4 * v.len + 60) begin
                chk("burst_timeout", 1'b0, 1'b1);
                fin = 1'b1;
            end
            if (!fin) @(posedge clk);
        end
    endtask

    initial begin
        int popped;
        tests = 0; fails = 0;
        rstn = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 16; i++) mem[i] = {16'hC0DE, 16'(i), 32'hFACE_0000 + 32'(i)};

        #3;
        chk_quiet("reset");
        chk("reset_addr", sram_address, '0);
        chk("reset_data", out_data, '0);
        chk("reset_last", out_last, 1'b0);
        #19 rstn = 1'b1;

        //        base  len  pct x1  x2  exp_done
        tbl[0] = '{0,    16, 100, 0,  0,  19};
        tbl[1] = '{0,    16,  60, 0,  0,  0};
        tbl[2] = '{1020,  8, 100, 0,  0,  11};
        tbl[3] = '{5,     0, 100, 0,  0,  1};
        tbl[4] = '{100,  20, 100, 5,  23, 23};
        tbl[5] = '{200,   1, 100, 0,  0,  4};
        tbl[6] = '{300,   2,  50, 0,  0,  0};
        tbl[7] = '{7,  1024, 100, 0,  0,  1027};
        for (int i = 8; i < 14; i++) begin
            tbl[i] = '{int'($urandom_range(1023)), int'($urandom_range(1, 40)),
                       int'($urandom_range(40, 100)), int'($urandom_range(2, 10)), 0, 0};
        end
        for (int i = 0; i < 14; i++) run_burst(tbl[i]);

        // Idle after a burst: nothing moves without start
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_quiet("idle");
        end

        // Reset in the middle of a 16-word burst, after beat 5
        @(posedge clk); #1;
        base_addr = '0; length = 11'd16; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        popped = 0;
        for (int i = 0; i < 40 && popped < 5; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) popped++;
        end
        chk("reset_reach_beat5", popped, 5);
        #2 rstn = 1'b0;
        #1;
        chk_quiet("async_rst");
        chk("async_rst_addr", sram_address, '0);
        chk("async_rst_data", out_data, '0);
        chk("async_rst_last", out_last, 1'b0);
        @(posedge clk);
        @(negedge clk); #2 rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_quiet("post_rst");
        end
        run_burst('{0, 16, 100, 0, 0, 19});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
